// File: rtl/reset_map_pkg.sv
// Reset vector bit map shared by heartbeat, the PWM/quad/PID blocks and the
// reset release sequencer.
package reset_map_pkg;

  localparam logic [31:0] RST_PWM_MASK    = 32'h000000FF;
  localparam logic [31:0] RST_QUAD_MASK   = 32'h000FFF00;
  localparam logic [31:0] RST_PID_MASK    = 32'h0FF00000;
  localparam int          RST_PIDCLK_BIT  = 28;
  localparam logic [31:0] RST_PIDCLK_MASK = 32'h10000000;
  localparam logic [31:0] RST_SPARE_MASK  = 32'hE0000000;

  // Gated groups in chain order: 0 = PID, 1 = QUAD, 2 = PWM.
  localparam int NUM_GATES = 3;

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Reset request / sequenced reset bundle between heartbeat, sequencer and
// the peripherals.
interface reset_release_sequencer_if;

  logic [31:0] req_rst;
  logic [31:0] rst_out;
  logic [2:0]  gates_open;
  logic        all_released;

  modport master (output req_rst, input rst_out, gates_open, all_released);
  modport slave  (input req_rst, output rst_out, gates_open, all_released);

endinterface

// File: rtl/release_gate.sv
// Settle counter for one downstream group: the gate opens only after the
// upstream group has stayed fully released for SETTLE_CYCLES clocks.
module release_gate #(
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic upstream_held,
  output logic gate
);

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Clear on any upstream hold, otherwise count up and park at SETTLE.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n)             cnt <= '0;
    else if (upstream_held) cnt <= '0;
    else if (cnt != SETTLE) cnt <= cnt + 1'b1;
  end

  // Qualify with the live hold so the gate shuts in the re-assert cycle.
  assign gate = (cnt == SETTLE) && !upstream_held;

endmodule

// File: rtl/reset_release_sequencer.sv
// Resynchronises the slow-clock reset vector and releases peripheral resets
// in the order PID clock -> PID -> quad -> PWM; assertion is never delayed
// beyond the synchroniser.
module reset_release_sequencer
  import reset_map_pkg::*;
#(
  parameter int SETTLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input logic                     clk_50Mhz,
  input logic                     rst_n,
  reset_release_sequencer_if.slave bus
);

  // Upstream group feeding each gate, and the group that gate controls.
  localparam logic [NUM_GATES-1:0][31:0] UP_MASK =
    {RST_QUAD_MASK, RST_PID_MASK, RST_PIDCLK_MASK};
  localparam logic [NUM_GATES-1:0][31:0] DN_MASK =
    {RST_PWM_MASK, RST_QUAD_MASK, RST_PID_MASK};

  logic [31:0]          sync1, req_s, rst_q, hold_mask;
  logic [NUM_GATES-1:0] held, gate;

  // Two-flop synchroniser; resets to "held" so nothing releases early.
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      req_s <= '1;
    end else begin
      sync1 <= bus.req_rst;
      req_s <= sync1;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    assign held[g] = |(rst_q & UP_MASK[g]);
    release_gate #(
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_gate (
      .clk_50Mhz    (clk_50Mhz),
      .rst_n        (rst_n),
      .upstream_held(held[g]),
      .gate         (gate[g])
    );
  end

  // Every closed gate forces its whole group into reset.
  always_comb begin
    hold_mask = '0;
    for (int g = 0; g < NUM_GATES; g++)
      if (!gate[g]) hold_mask = hold_mask | DN_MASK[g];
  end

  // Registered resets: request OR sequencing hold (CLK/spare never gated).
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) rst_q <= '1;
    else        rst_q <= req_s | hold_mask;
  end

  assign bus.rst_out      = rst_q;
  assign bus.gates_open   = gate;
  assign bus.all_released = (rst_q[28:0] == 29'd0);

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed scenarios with fixed edge
// expectations plus a time-based reference model checked every cycle.
module tb_reset_release_sequencer;
  import reset_map_pkg::*;

  localparam int S  = 4;
  localparam int CW = 3;  // narrow on purpose: a wrapping counter would show

  localparam logic [31:0] ALL_GATED = RST_PID_MASK | RST_QUAD_MASK | RST_PWM_MASK;

  logic clk_50Mhz = 1'b0;
  logic rst_n     = 1'b0;

  reset_release_sequencer_if bus();

  reset_release_sequencer #(.SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .clk_50Mhz(clk_50Mhz),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_50Mhz = ~clk_50Mhz;

  int checks = 0;
  int errors = 0;

  // Reference model: a group may leave reset once its upstream group has
  // been all-zero for more than S edges (tracked as "edge of last hold").
  logic [31:0] up_m [3];
  logic [31:0] dn_m [3];
  logic [31:0] exp_rst = '1;
  logic [31:0] m_s1 = '1, m_s2 = '1;
  int          n_edge = 0;
  int          last_held [3] = '{0, 0, 0};

  initial begin
    up_m = '{RST_PIDCLK_MASK, RST_PID_MASK, RST_QUAD_MASK};
    dn_m = '{RST_PID_MASK, RST_QUAD_MASK, RST_PWM_MASK};
  end

  initial begin
    logic [31:0] hold;
    forever begin
      @(posedge clk_50Mhz or negedge rst_n);
      if (!rst_n) begin
        exp_rst = '1; m_s1 = '1; m_s2 = '1; n_edge = 0;
        for (int g = 0; g < 3; g++) last_held[g] = 0;
      end else begin
        hold = '0;
        for (int g = 0; g < 3; g++)
          if (!(((exp_rst & up_m[g]) == 0) && (n_edge - last_held[g] > S)))
            hold |= dn_m[g];
        n_edge++;
        exp_rst = m_s2 | hold;
        m_s2 = m_s1;
        m_s1 = bus.req_rst;
        for (int g = 0; g < 3; g++)
          if ((exp_rst & up_m[g]) != 0) last_held[g] = n_edge;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    logic [2:0] eg;
    forever begin
      @(negedge clk_50Mhz);
      for (int g = 0; g < 3; g++)
        eg[g] = ((exp_rst & up_m[g]) == 0) && (n_edge - last_held[g] > S);
      checks++;
      if (bus.rst_out !== exp_rst || bus.gates_open !== eg ||
          bus.all_released !== (exp_rst[28:0] == 29'd0)) begin
        errors++;
        $display("FAIL model t=%0t rst_out=%h/%h gates=%b/%b all_rel=%b (got/exp)",
                 $time, bus.rst_out, exp_rst, bus.gates_open, eg, bus.all_released);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_rst = '0;
    @(negedge clk_50Mhz);
    checks++;
    if (bus.rst_out !== 32'hFFFFFFFF || bus.gates_open !== 3'b000 ||
        bus.all_released !== 1'b0) begin
      errors++;
      $display("FAIL reset rst_out=%h gates=%b all_rel=%b expected FFFFFFFF/000/0",
               bus.rst_out, bus.gates_open, bus.all_released);
    end
  endtask

  // Expects rst_n released before the next rising edge (edge 1).
  task automatic check_powerup(input string tag);
    logic [31:0] e;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_50Mhz);
      e = '0;
      if (k < 3)  e |= RST_PIDCLK_MASK | RST_SPARE_MASK;
      if (k < 8)  e |= RST_PID_MASK;
      if (k < 13) e |= RST_QUAD_MASK;
      if (k < 18) e |= RST_PWM_MASK;
      checks++;
      if (bus.rst_out !== e) begin
        errors++;
        $display("FAIL %s edge %0d rst_out=%h expected %h", tag, k, bus.rst_out, e);
      end
      if (k >= 18) begin
        checks++;
        if (bus.gates_open !== 3'b111 || bus.all_released !== 1'b1) begin
          errors++;
          $display("FAIL %s edge %0d gates=%b all_rel=%b expected 111/1",
                   tag, k, bus.gates_open, bus.all_released);
        end
      end
    end
  endtask

  task automatic test_powerup();
    bus.req_rst = '0;
    rst_n = 1'b1;
    check_powerup("powerup");
  endtask

  task automatic test_pwm_req();
    logic [31:0] e;
    bus.req_rst = RST_PWM_MASK;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk_50Mhz);
      e = (j >= 3) ? RST_PWM_MASK : 32'h0;
      checks++;
      if (bus.rst_out !== e || bus.gates_open !== 3'b111) begin
        errors++;
        $display("FAIL pwm_req j=%0d rst_out=%h gates=%b expected %h/111",
                 j, bus.rst_out, bus.gates_open, e);
      end
    end
    bus.req_rst = '0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk_50Mhz);
      e = (j >= 3) ? 32'h0 : RST_PWM_MASK;
      checks++;
      if (bus.rst_out !== e) begin
        errors++;
        $display("FAIL pwm_clear j=%0d rst_out=%h expected %h", j, bus.rst_out, e);
      end
    end
  endtask

  task automatic test_clk_pulse();
    logic [31:0] e;
    bus.req_rst = RST_PIDCLK_MASK;
    for (int j = 1; j <= 22; j++) begin
      @(negedge clk_50Mhz);
      if (j == 1) bus.req_rst = '0;
      e = '0;
      if (j == 3)            e |= RST_PIDCLK_MASK;
      if (j >= 4 && j < 9)   e |= RST_PID_MASK;
      if (j >= 5 && j < 14)  e |= RST_QUAD_MASK;
      if (j >= 6 && j < 19)  e |= RST_PWM_MASK;
      checks++;
      if (bus.rst_out !== e) begin
        errors++;
        $display("FAIL clk_pulse j=%0d rst_out=%h expected %h", j, bus.rst_out, e);
      end
    end
  endtask

  task automatic test_pid_bit();
    logic [31:0] e;
    e = 32'h00400000 | RST_QUAD_MASK | RST_PWM_MASK;
    bus.req_rst = 32'h00400000;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk_50Mhz);
      if (j >= 6) begin
        checks++;
        if (bus.rst_out !== e || bus.gates_open !== 3'b001 || bus.all_released !== 1'b0) begin
          errors++;
          $display("FAIL pid_bit j=%0d rst_out=%h gates=%b expected %h/001",
                   j, bus.rst_out, bus.gates_open, e);
        end
      end
    end
    bus.req_rst = '0;
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk_50Mhz);
      if (j == 12 || j == 13) begin
        checks++;
        if (bus.all_released !== (j == 13)) begin
          errors++;
          $display("FAIL pid_release j=%0d all_rel=%b expected %b",
                   j, bus.all_released, (j == 13));
        end
      end
    end
  endtask

  task automatic test_spare();
    logic [31:0] e;
    bus.req_rst = 32'h40000000;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk_50Mhz);
      e = (j >= 3) ? 32'h40000000 : 32'h0;
      checks++;
      if (bus.rst_out !== e || bus.gates_open !== 3'b111 || bus.all_released !== 1'b1) begin
        errors++;
        $display("FAIL spare_set j=%0d rst_out=%h gates=%b expected %h/111",
                 j, bus.rst_out, bus.gates_open, e);
      end
    end
    bus.req_rst = '0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk_50Mhz);
      e = (j >= 3) ? 32'h0 : 32'h40000000;
      checks++;
      if (bus.rst_out !== e || bus.gates_open !== 3'b111) begin
        errors++;
        $display("FAIL spare_clr j=%0d rst_out=%h gates=%b expected %h/111",
                 j, bus.rst_out, bus.gates_open, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    @(negedge clk_50Mhz);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50Mhz);  // PID out, QUAD still settling
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rst_out !== 32'hFFFFFFFF || bus.gates_open !== 3'b000 ||
        bus.all_released !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset rst_out=%h gates=%b all_rel=%b expected FFFFFFFF/000/0",
               bus.rst_out, bus.gates_open, bus.all_released);
    end
    #1 rst_n = 1'b1;
    check_powerup("mid_reset_restart");
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 120; it++) begin
      r = int'($urandom_range(0, 4));
      case (r)
        0:       bus.req_rst = '0;
        1:       bus.req_rst = 32'h1 << $urandom_range(0, 31);
        2:       bus.req_rst = bus.req_rst ^ (32'h1 << $urandom_range(0, 31));
        3:       bus.req_rst = $urandom() & $urandom() & $urandom();
        default: ;
      endcase
      repeat ($urandom_range(1, 12)) @(negedge clk_50Mhz);
    end
    bus.req_rst = '0;
    repeat (30) @(negedge clk_50Mhz);
    checks++;
    if (bus.rst_out !== 32'h0 || bus.gates_open !== 3'b111) begin
      errors++;
      $display("FAIL random_drain rst_out=%h gates=%b expected 0/111",
               bus.rst_out, bus.gates_open);
    end
  endtask

  initial begin
    bus.req_rst = '0;
    test_reset();
    test_powerup();
    test_pwm_req();
    test_clk_pulse();
    test_pid_bit();
    test_spare();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
